// File: rtl/sync_word_framer.sv
// Sync word framer: prepends SYNC_VAL to every PAYLOAD_LEN-word frame on a valid/ready link.
// Optional byte-stuffing of SYNC_VAL/ESC_VAL payload words under SYNC_FRAMER_ESCAPE_EN.
module sync_word_framer #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  SYNC_VAL    = 8'h45,
  parameter int                PAYLOAD_LEN = 16,
  parameter int                CNT_WIDTH   = 8,
  parameter logic [WIDTH-1:0]  ESC_VAL     = 8'h7D,
  parameter logic [WIDTH-1:0]  ESC_MASK    = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_PAYLOAD = 2'd1
`ifdef SYNC_FRAMER_ESCAPE_EN
    ,ST_ESC    = 2'd2
`endif
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]      r_out_dat, w_dat_nxt;
  logic                  r_out_valid, w_valid_nxt;
  logic                  r_out_sof, w_sof_nxt;
  logic                  w_load;
  logic                  w_last;

`ifdef SYNC_FRAMER_ESCAPE_EN
  logic [WIDTH-1:0]      r_hold, w_hold_nxt;
  logic                  r_esc_last, w_esc_last_nxt;
`else
  logic [WIDTH-1:0]      w_unused_esc;
  assign w_unused_esc = ESC_VAL ^ ESC_MASK;
`endif

  assign w_load    = !r_out_valid | out_ready;
  assign w_last    = (r_cnt == LAST);
  assign in_ready  = w_load & (r_state == ST_PAYLOAD) & !rst;
  assign out_dat   = r_out_dat;
  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dat_nxt   = r_out_dat;
    w_valid_nxt = r_out_valid;
    w_sof_nxt   = r_out_sof;
`ifdef SYNC_FRAMER_ESCAPE_EN
    w_hold_nxt     = r_hold;
    w_esc_last_nxt = r_esc_last;
`endif
    if (w_load) begin
      // An empty slot clears sof too so a stale flag never lingers on idle cycles
      w_valid_nxt = 1'b0;
      w_sof_nxt   = 1'b0;
      case (r_state)
        ST_SYNC: begin
          if (in_valid) begin
            w_dat_nxt   = SYNC_VAL;
            w_sof_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (in_valid) begin
            w_dat_nxt   = in_dat;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = w_last ? '0 : r_cnt + 1'b1;
`ifdef SYNC_FRAMER_ESCAPE_EN
            // Escaped word: frame-end decision is carried through ESC in r_esc_last
            if (in_dat == SYNC_VAL || in_dat == ESC_VAL) begin
              w_dat_nxt      = ESC_VAL;
              w_hold_nxt     = in_dat ^ ESC_MASK;
              w_esc_last_nxt = w_last;
              w_state_nxt    = ST_ESC;
            end else
`endif
            if (w_last) w_state_nxt = ST_SYNC;
          end
        end
`ifdef SYNC_FRAMER_ESCAPE_EN
        ST_ESC: begin
          w_dat_nxt   = r_hold;
          w_valid_nxt = 1'b1;
          w_state_nxt = r_esc_last ? ST_SYNC : ST_PAYLOAD;
        end
`endif
        default: w_state_nxt = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SYNC;
      r_cnt       <= '0;
      r_out_dat   <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
`ifdef SYNC_FRAMER_ESCAPE_EN
      r_hold      <= '0;
      r_esc_last  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_dat   <= w_dat_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_sof   <= w_sof_nxt;
`ifdef SYNC_FRAMER_ESCAPE_EN
      r_hold      <= w_hold_nxt;
      r_esc_last  <= w_esc_last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sync_word_framer.sv
// Bench for sync_word_framer: expected link stream built from accepted input words and frame rules.
module tb_sync_word_framer;

  localparam int          LEN  = 4;
  localparam logic [7:0]  SYNC = 8'h45;
  localparam logic [7:0]  ESC  = 8'h7D;
  localparam logic [7:0]  MASK = 8'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_dat;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid, out_sof;
  logic [7:0] out_dat;

  logic       b_rst;
  logic       b_in_ready, b_out_valid, b_out_sof;
  logic [7:0] b_out_dat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_word_framer #(.WIDTH(8), .SYNC_VAL(SYNC), .PAYLOAD_LEN(LEN), .CNT_WIDTH(8),
                     .ESC_VAL(ESC), .ESC_MASK(MASK)) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof));

  sync_word_framer #(.WIDTH(8), .SYNC_VAL(SYNC), .PAYLOAD_LEN(1), .CNT_WIDTH(8),
                     .ESC_VAL(ESC), .ESC_MASK(MASK)) dut_len1 (
    .clk(clk), .rst(b_rst), .in_dat(8'hA5), .in_valid(1'b1), .in_ready(b_in_ready),
    .out_dat(b_out_dat), .out_valid(b_out_valid), .out_ready(1'b1), .out_sof(b_out_sof));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: one expected beat per link word, {data, sof}
  typedef struct packed { logic [7:0] d; logic s; } beat_t;
  beat_t exp_q[$];
  int    acc_cnt;

  function automatic void model_reset();
    exp_q.delete();
    exp_q.push_back('{d: SYNC, s: 1'b1});
    acc_cnt = 0;
  endfunction

  function automatic void model_accept(input logic [7:0] w);
`ifdef SYNC_FRAMER_ESCAPE_EN
    if (w == SYNC || w == ESC) begin
      exp_q.push_back('{d: ESC, s: 1'b0});
      exp_q.push_back('{d: w ^ MASK, s: 1'b0});
    end else
`endif
    exp_q.push_back('{d: w, s: 1'b0});
    acc_cnt++;
    if (acc_cnt % LEN == 0) exp_q.push_back('{d: SYNC, s: 1'b1});
  endfunction

  logic       rst_q = 1'b0;
  logic       stall_q = 1'b0;
  logic [7:0] dat_q;
  logic       sof_q;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      if (rst_q) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sof", out_sof, 0);
        chk("rst_out_dat", out_dat, 0);
      end
      model_reset();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_dat", out_dat, dat_q);
        chk("hold_sof", out_sof, sof_q);
      end
      chk("in_ready_vs_load", in_ready & out_valid & ~out_ready, 0);
      if (out_valid && out_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_dat", out_dat, e.d);
          chk("beat_sof", out_sof, e.s);
        end
      end
      if (in_valid && in_ready) model_accept(in_dat);
      stall_q = out_valid && !out_ready;
      dat_q   = out_dat;
      sof_q   = out_sof;
    end
    rst_q = rst;
  end

  initial begin
    logic acc;
    logic b_sof_q;
    int   r;
    rst = 1'b1; b_rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_dat = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_dat", out_dat, 0);
    chk("len1_reset_valid", b_out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0; b_rst = 1'b0;

    // Streaming with no stalls: out_valid stays high; LEN=1 alternates S,P
    in_valid = 1'b1; out_ready = 1'b1; in_dat = 8'h01;
    b_sof_q = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      if (i > 0) begin
        chk("stream_valid", out_valid, 1);
        chk("len1_sof", b_out_sof, !b_sof_q);
        chk("len1_dat", b_out_dat, b_sof_q ? 8'hA5 : SYNC);
      end
      b_sof_q = b_out_sof;
      @(posedge clk); #1;
      if (acc) in_dat = in_dat + 8'd1;
    end

    // Backpressure: three stalled cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) in_dat = in_dat + 8'd1;
    end
    out_ready = 1'b1;

    // Source gap of two cycles
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) chk("gap_valid", out_valid, 0);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) in_dat = in_dat + 8'd1;
    end
    in_valid = 1'b1;
    @(negedge clk);
    chk("gap_valid2", out_valid, 0);
    acc = in_valid & in_ready;
    @(posedge clk); #1;
    if (acc) in_dat = in_dat + 8'd1;

    // Mid-frame reset, then restart at 0x10
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_dat = 8'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) in_dat = in_dat + 8'd1;
    end

    // Random traffic, escape-prone data, occasional reset
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 7));
      in_dat    = (r == 0) ? SYNC : (r == 1) ? ESC : 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // Drain: every accepted word must have left the framer
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", (exp_q.size() == 0) || (exp_q.size() == 1 && exp_q[0].s), 1);
    chk("drain_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
